// File: rtl/if_prefetch.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// if_prefetch
// Instruction-fetch front end for the 5-stage RV32 core. Issues word fetches
// over a req/gnt/rvalid handshake with variable latency, buffers returned
// words with their PCs in a small in-order queue, and hands one {PC, instr}
// pair per cycle to the IF/ID register. A redirect throws away everything
// queued and arranges for in-flight responses to be dropped on arrival.
//
// Ports
//   clk, rst_n              core clock, async active-low reset
//   imem_req/imem_addr      fetch request and word-aligned byte address
//   imem_gnt                request accepted this cycle
//   imem_rvalid/imem_rdata  in-order response for the oldest request
//   redirect/redirect_pc    taken branch/jump and its target
//   id_valid/id_pc/id_instr queue head towards decode
//   id_ready                decode takes the head this cycle
// ---------------------------------------------------------------------------
module if_prefetch #(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  input  logic        id_ready
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned SW = CW + 1;
  localparam logic [SW-1:0] DEPTH_S = SW'(DEPTH);
  localparam logic [OW-1:0] MAXO_C  = OW'(MAX_OUTSTANDING);

  logic [31:0]   fetchPc_q, fetchPc_d;
  logic [31:0]   fillPc_q, fillPc_d;
  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic [OW-1:0] outstanding_q, outstanding_d;
  logic [OW-1:0] discard_q, discard_d;

  logic [31:0]   pcMem_q    [DEPTH];
  logic [31:0]   instrMem_q [DEPTH];

  logic rspValid;
  logic push;
  logic pop;
  logic accept;
  logic [31:0] redirectAligned;
  logic unusedRedirectLsb;

  assign redirectAligned   = {redirect_pc[31:2], 2'b00};
  assign unusedRedirectLsb = ^redirect_pc[1:0];

  // Requests reserve a queue slot up front (outstanding + count < DEPTH), so
  // every accepted word is guaranteed a place and the queue cannot overflow.
  assign imem_req  = rst_n && !redirect && (outstanding_q < MAXO_C) &&
                     ((SW'(outstanding_q) + SW'(count_q)) < DEPTH_S);
  assign imem_addr = fetchPc_q;
  assign accept    = imem_req && imem_gnt;

  // A response with nothing in flight is ignored; responses during a redirect
  // or while stale words are still owed are dropped instead of queued.
  assign rspValid = imem_rvalid && (outstanding_q != '0);
  assign push     = rspValid && !redirect && (discard_q == '0);
  assign pop      = id_valid && id_ready && !redirect;

  assign id_valid = (count_q != '0);
  assign id_pc    = id_valid ? pcMem_q[rdPtr_q]    : 32'h0;
  assign id_instr = id_valid ? instrMem_q[rdPtr_q] : 32'h0;

  always_comb begin
    fetchPc_d     = fetchPc_q;
    fillPc_d      = fillPc_q;
    wrPtr_d       = wrPtr_q;
    rdPtr_d       = rdPtr_q;
    count_d       = count_q;
    discard_d     = discard_q;
    outstanding_d = outstanding_q + OW'(accept) - OW'(rspValid);

    if (redirect) begin
      fetchPc_d = redirectAligned;
      fillPc_d  = redirectAligned;
      wrPtr_d   = '0;
      rdPtr_d   = '0;
      count_d   = '0;
      // Everything still in flight after this cycle belongs to the old path.
      discard_d = outstanding_q - OW'(rspValid);
    end else begin
      if (accept) begin
        fetchPc_d = fetchPc_q + 32'd4;
      end
      if (push) begin
        fillPc_d = fillPc_q + 32'd4;
        wrPtr_d  = wrPtr_q + AW'(1);
      end
      if (pop) begin
        rdPtr_d = rdPtr_q + AW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
      if (rspValid && (discard_q != '0)) begin
        discard_d = discard_q - OW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetchPc_q     <= RESET_PC;
      fillPc_q      <= RESET_PC;
      wrPtr_q       <= '0;
      rdPtr_q       <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetchPc_q     <= fetchPc_d;
      fillPc_q      <= fillPc_d;
      wrPtr_q       <= wrPtr_d;
      rdPtr_q       <= rdPtr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  // Queue storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (push) begin
      pcMem_q[wrPtr_q]    <= fillPc_q;
      instrMem_q[wrPtr_q] <= imem_rdata;
    end
  end

  // Memory must never answer when nothing is in flight.
  assert property (@(posedge clk) disable iff (!rst_n)
                   imem_rvalid |-> (outstanding_q != '0));

endmodule

// File: tb/tb_if_prefetch.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_if_prefetch
// Drives if_prefetch against a variable-latency in-order memory model and
// compares every instruction handed to decode with a scoreboard of the words
// fetched on the current path.
// ---------------------------------------------------------------------------
module tb_if_prefetch;

  localparam int MAXO = 2;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } memReq_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } sbEntry_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        id_ready = 1'b1;

  memReq_t  memQ[$];
  sbEntry_t sbQ[$];

  int          assertCount = 0;
  int          failCount = 0;
  int          cyc = 0;
  int          latMin = 1;
  int          latMax = 1;
  bit          gntRand = 1'b0;
  logic [31:0] nextAddr = 32'h0;
  int          popCount = 0;
  bit          sawFirst = 1'b0;
  logic [31:0] firstPc = 32'h0;
  logic        reqPrev = 1'b0;
  logic        gntPrev = 1'b0;
  logic [31:0] addrPrev = 32'h0;
  int          firstCycle;
  int          popBase;
  bit          found;

  if_prefetch #(
    .DEPTH(4),
    .MAX_OUTSTANDING(MAXO),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .id_valid(id_valid),
    .id_pc(id_pc),
    .id_instr(id_instr),
    .id_ready(id_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic redir, input logic [31:0] pc, input logic rdy);
    @(posedge clk);
    #2;
    redirect    = redir;
    redirect_pc = pc;
    id_ready    = rdy;
  endtask

  // Waits (bounded) for the first instruction popped after the last redirect.
  task automatic waitFirstPop(input string tag, input logic [31:0] expected);
    for (int k = 0; k < 40; k++) begin
      if (sawFirst) break;
      @(posedge clk);
    end
    checkOutput(tag, sawFirst ? firstPc : 32'hFFFF_FFFF, expected);
  endtask

  // Memory model: answers the oldest granted request once its latency has
  // elapsed, and randomises the grant when asked to.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (memQ.size() > 0 && memQ[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memWord(memQ[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
    imem_gnt = gntRand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: mid-cycle, records what the coming edge will do. Grants push the
  // expected {pc, instr} to the scoreboard, pops are compared against it, and
  // a redirect discards every expectation on the old path.
  always @(negedge clk) begin
    if (rst_n) begin
      if (imem_rvalid && memQ.size() > 0) void'(memQ.pop_front());
      if (reqPrev && !gntPrev && !redirect) begin
        checkOutput("reqHold", {31'b0, imem_req}, 32'd1);
        checkOutput("addrHold", imem_addr, addrPrev);
      end
      if (redirect) begin
        checkOutput("reqInRedirect", {31'b0, imem_req}, 32'd0);
        sbQ.delete();
        nextAddr = {redirect_pc[31:2], 2'b00};
        sawFirst = 1'b0;
      end else begin
        if (id_valid && id_ready) begin
          if (sbQ.size() == 0) begin
            checkOutput("popWithoutExpect", 32'(sbQ.size()), 32'd1);
          end else begin
            sbEntry_t e;
            e = sbQ.pop_front();
            checkOutput("idPc", id_pc, e.pc);
            checkOutput("idInstr", id_instr, e.instr);
            popCount++;
            if (!sawFirst) begin
              sawFirst = 1'b1;
              firstPc  = id_pc;
            end
          end
        end
        if (imem_req && imem_gnt) begin
          checkOutput("fetchAddr", imem_addr, nextAddr);
          memQ.push_back('{imem_addr, cyc + int'($urandom_range(latMin, latMax))});
          sbQ.push_back('{nextAddr, memWord(nextAddr)});
          nextAddr = nextAddr + 32'd4;
        end
      end
      if (!id_valid) begin
        checkOutput("idPcEmpty", id_pc, 32'h0);
        checkOutput("idInstrEmpty", id_instr, 32'h0);
      end
      checkOutput("outstandingMax", {31'b0, memQ.size() <= MAXO}, 32'd1);
      reqPrev  = imem_req;
      gntPrev  = imem_gnt;
      addrPrev = imem_addr;
    end
  end

  // Main sequence: reset, streaming, backpressure, redirect corner cases,
  // then a long randomised run.
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rstReq", {31'b0, imem_req}, 32'd0);
    checkOutput("rstAddr", imem_addr, 32'h0);
    checkOutput("rstValid", {31'b0, id_valid}, 32'd0);
    checkOutput("rstPc", id_pc, 32'h0);
    checkOutput("rstInstr", id_instr, 32'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Sequential streaming at latency 1: first output in cycle 3, then one
    // instruction every cycle.
    firstCycle = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (id_valid && firstCycle == 0) firstCycle = k;
    end
    checkOutput("firstValidCycle", firstCycle, 32'd3);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checkOutput("streamValid", {31'b0, id_valid}, 32'd1);
    end

    // Backpressure: restart at 0 with decode stalled; the queue fills and
    // requests stop, then 0x0..0xC drain in order.
    applyStimulus(1'b1, 32'h0, 1'b0);
    for (int k = 0; k < 10; k++) applyStimulus(1'b0, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("bpValid", {31'b0, id_valid}, 32'd1);
    checkOutput("bpPc", id_pc, 32'h0);
    checkOutput("bpReq", {31'b0, imem_req}, 32'd0);
    checkOutput("bpOutstanding", memQ.size(), 32'd0);
    popBase = popCount;
    for (int k = 0; k < 8; k++) applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("bpFirstPc", firstPc, 32'h0);
    checkOutput("bpDrained", {31'b0, (popCount - popBase) >= 4}, 32'd1);

    // Redirect with two requests in flight and none answering this cycle.
    latMin = 4;
    latMax = 4;
    for (int k = 0; k < 8; k++) applyStimulus(1'b0, 32'h0, 1'b1);
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      @(posedge clk);
      #2;
      if (memQ.size() == 2 && !imem_rvalid) found = 1'b1;
    end
    checkOutput("twoOutstandingSeen", {31'b0, found}, 32'd1);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    applyStimulus(1'b0, 32'h0, 1'b1);
    waitFirstPop("redirFirstPc", 32'h0000_0100);

    // Redirect in the same cycle as a response and a would-be pop.
    latMin = 1;
    latMax = 1;
    for (int k = 0; k < 8; k++) applyStimulus(1'b0, 32'h0, 1'b1);
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      @(posedge clk);
      #2;
      if (imem_rvalid && id_valid) found = 1'b1;
    end
    checkOutput("rspPopSeen", {31'b0, found}, 32'd1);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0400;
    applyStimulus(1'b0, 32'h0, 1'b1);
    @(negedge clk);
    checkOutput("flushEmpty", {31'b0, id_valid}, 32'd0);
    waitFirstPop("flushFirstPc", 32'h0000_0400);

    // Back-to-back redirects while responses are pending.
    latMin = 3;
    latMax = 3;
    for (int k = 0; k < 6; k++) applyStimulus(1'b0, 32'h0, 1'b1);
    applyStimulus(1'b1, 32'h0000_0200, 1'b1);
    applyStimulus(1'b1, 32'h0000_0300, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    waitFirstPop("b2bFirstPc", 32'h0000_0300);

    // Randomised run: grant stalls, latency 1..5, random decode stalls and
    // occasional redirects.
    latMin  = 1;
    latMax  = 5;
    gntRand = 1'b1;
    popBase = popCount;
    for (int k = 0; k < 1000; k++) begin
      applyStimulus(($urandom_range(0, 49) == 0), $urandom, 1'($urandom_range(0, 1)));
    end
    applyStimulus(1'b0, 32'h0, 1'b1);
    gntRand = 1'b0;
    repeat (20) @(posedge clk);
    checkOutput("randomProgress", {31'b0, (popCount - popBase) > 50}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
